// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: N-way arbiter with round-robin or fixed-priority selection and registered grants.
// Optional hold-limit preemption is compiled in when ARB_HOLD_LIMIT_EN is defined.
module rr_arbiter_param #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic           i_mode,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_busy
);

    if (N < 2 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_arbiter_param: requires N >= 2 and MAX_HOLD >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [N-1:0]   gnt_r, gnt_nxt_s;
    logic [IDW-1:0] gnt_id_r, gnt_id_nxt_s;
    logic [IDW-1:0] last_owner_r, last_owner_nxt_s;
    logic           busy_r;
    logic [N-1:0]   pool_s;
    logic [IDW-1:0] win_s;
    logic           owner_req_s;
    logic           preempt_s;

    // Round-robin scans upward from last+1 with wrap; fixed priority takes the lowest index.
    function automatic logic [IDW-1:0] pick_winner(input logic [N-1:0]   req,
                                                   input logic           mode,
                                                   input logic [IDW-1:0] last);
        logic [IDW-1:0] win;
        logic           found;
        int             idx;
        win   = {IDW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = mode ? k : ((int'(last) + k + 1) % N);
            if (!found && req[idx]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // The current owner never competes in its own handoff; in IDLE gnt_r is zero.
    assign pool_s      = i_req & ~gnt_r;
    assign owner_req_s = |(i_req & gnt_r);
    assign win_s       = pick_winner(pool_s, i_mode, last_owner_r);

`ifdef ARB_HOLD_LIMIT_EN
    localparam int             HCW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_SAT = HCW'(MAX_HOLD - 1);

    logic [HCW-1:0] hold_cnt_r, hold_cnt_nxt_s;

    assign preempt_s = (state_r == ST_GRANT) && (hold_cnt_r == HOLD_SAT) && (|pool_s);

    // Hold counter: saturate while the owner keeps the grant, clear on every new grant.
    always_comb begin
        hold_cnt_nxt_s = {HCW{1'b0}};
        if (state_nxt_s == ST_GRANT && state_r == ST_GRANT && gnt_nxt_s == gnt_r) begin
            if (hold_cnt_r != HOLD_SAT) begin
                hold_cnt_nxt_s = hold_cnt_r + HCW'(1'b1);
            end else begin
                hold_cnt_nxt_s = hold_cnt_r;
            end
        end else begin
            hold_cnt_nxt_s = {HCW{1'b0}};
        end
    end

    // Hold counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt_r <= {HCW{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end
`else
    assign preempt_s = 1'b0;
`endif

    // Next-state and next-grant decision.
    always_comb begin
        state_nxt_s      = state_r;
        gnt_nxt_s        = gnt_r;
        gnt_id_nxt_s     = gnt_id_r;
        last_owner_nxt_s = last_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (|pool_s) begin
                    state_nxt_s      = ST_GRANT;
                    gnt_nxt_s        = {{(N-1){1'b0}}, 1'b1} << win_s;
                    gnt_id_nxt_s     = win_s;
                    last_owner_nxt_s = win_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    gnt_nxt_s    = {N{1'b0}};
                    gnt_id_nxt_s = {IDW{1'b0}};
                end
            end
            ST_GRANT: begin
                if (owner_req_s && !preempt_s) begin
                    state_nxt_s = ST_GRANT;
                end else if (|pool_s) begin
                    // Direct handoff: no idle cycle between owners.
                    state_nxt_s      = ST_GRANT;
                    gnt_nxt_s        = {{(N-1){1'b0}}, 1'b1} << win_s;
                    gnt_id_nxt_s     = win_s;
                    last_owner_nxt_s = win_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    gnt_nxt_s    = {N{1'b0}};
                    gnt_id_nxt_s = {IDW{1'b0}};
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                gnt_nxt_s    = {N{1'b0}};
                gnt_id_nxt_s = {IDW{1'b0}};
            end
        endcase
    end

    // State and registered output update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {N{1'b0}};
            gnt_id_r     <= {IDW{1'b0}};
            last_owner_r <= IDW'(N - 1);
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            gnt_r        <= gnt_nxt_s;
            gnt_id_r     <= gnt_id_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            busy_r       <= |gnt_nxt_s;
        end
    end

    assign o_gnt    = gnt_r;
    assign o_gnt_id = gnt_id_r;
    assign o_busy   = busy_r;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Self-checking bench for rr_arbiter_param: directed plan sequences plus randomized traffic
// compared every cycle against an owner/last-owner reference model.
module tb_rr_arbiter_param;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = $clog2(N);
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic           i_clk  = 1'b0;
    logic           i_rst  = 1'b1;
    logic           i_mode = 1'b0;
    logic [N-1:0]   i_req  = 4'b1111;
    logic [N-1:0]   o_gnt;
    logic [IDW-1:0] o_gnt_id;
    logic           o_busy;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = idle), last granted index, consecutive hold cycles.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_hold  = 0;

    always #5 i_clk = ~i_clk;

    rr_arbiter_param #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_mode   (i_mode),
        .o_gnt    (o_gnt),
        .o_gnt_id (o_gnt_id),
        .o_busy   (o_busy)
    );

    function automatic int choose(input logic [N-1:0] pool, input logic mode, input int last);
        int w;
        int j;
        w = -1;
        for (int k = 0; k < N; k++) begin
            j = mode ? k : (last + 1 + k) % N;
            if (w < 0 && pool[j]) w = j;
        end
        return w;
    endfunction

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // Inputs change at negedge+1, so at negedge they equal what the DUT sampled at the last posedge.
    initial begin
        forever begin
            logic [N-1:0] pool;
            logic [N-1:0] eg;
            logic [IDW-1:0] eid;
            bit preempt;
            int w;
            @(negedge i_clk);
            if (i_rst) begin
                m_owner = -1;
                m_last  = N - 1;
                m_hold  = 0;
            end else begin
                pool = i_req;
                if (m_owner >= 0) pool[m_owner] = 1'b0;
                preempt = HOLD_EN && (m_owner >= 0) && (m_hold == MAX_HOLD - 1) && (pool != '0);
                if (m_owner >= 0 && i_req[m_owner] && !preempt) begin
                    if (m_hold < MAX_HOLD - 1) m_hold++;
                end else begin
                    w       = choose(pool, i_mode, m_last);
                    m_owner = w;
                    m_hold  = 0;
                    if (w >= 0) m_last = w;
                end
            end
            eg  = model_gnt();
            eid = (m_owner >= 0) ? IDW'(m_owner) : '0;
            total++;
            if (o_gnt !== eg) begin
                bad++;
                $display("FAIL cyc_gnt t=%0t got=%b want=%b", $time, o_gnt, eg);
            end
            total++;
            if (o_gnt_id !== eid) begin
                bad++;
                $display("FAIL cyc_gnt_id t=%0t got=%0d want=%0d", $time, o_gnt_id, eid);
            end
            total++;
            if (o_busy !== (m_owner >= 0)) begin
                bad++;
                $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, o_busy, (m_owner >= 0));
            end
            total++;
            if (!$onehot0(o_gnt)) begin
                bad++;
                $display("FAIL cyc_onehot t=%0t got=%b want=zero-or-onehot", $time, o_gnt);
            end
        end
    end

    task automatic step(input logic [N-1:0] req, input logic mode, input logic rst);
        i_req  = req;
        i_mode = mode;
        i_rst  = rst;
        @(negedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] exp);
        logic [IDW-1:0] eid;
        eid = '0;
        for (int j = 0; j < N; j++) if (exp[j]) eid = IDW'(j);
        total++;
        if (o_gnt !== exp || o_gnt_id !== eid || o_busy !== (|exp)) begin
            bad++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b, want gnt=%b id=%0d busy=%b",
                     name, o_gnt, o_gnt_id, o_busy, exp, eid, |exp);
        end
        total++;
        if (model_gnt() !== exp) begin
            bad++;
            $display("FAIL %s_model: got gnt=%b want=%b", name, model_gnt(), exp);
        end
    endtask

    initial begin
        logic [N-1:0] exp;
        logic [N-1:0] rq;
        logic         md;

        // Reset held three cycles with all requests high.
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, 1'b1);
            check("reset", 4'b0000);
        end
        step(4'b1111, 1'b0, 1'b0);
        check("first_after_reset", 4'b0001);
        step(4'b0000, 1'b0, 1'b0);
        check("release_idle", 4'b0000);

        // Single request held then dropped.
        step(4'b1000, 1'b0, 1'b0);
        check("single_grant", 4'b1000);
        step(4'b1000, 1'b0, 1'b0);
        check("single_hold", 4'b1000);
        step(4'b0000, 1'b0, 1'b0);
        check("single_release", 4'b0000);

        // Round-robin rotation with wrap; each owner drops for one cycle.
        step(4'b1111, 1'b0, 1'b0);
        check("rr_0", 4'b0001);
        step(4'b1110, 1'b0, 1'b0);
        check("rr_1", 4'b0010);
        step(4'b1101, 1'b0, 1'b0);
        check("rr_2", 4'b0100);
        step(4'b1011, 1'b0, 1'b0);
        check("rr_3", 4'b1000);
        step(4'b0111, 1'b0, 1'b0);
        check("rr_wrap", 4'b0001);
        step(4'b0000, 1'b1, 1'b0);
        check("rr_idle", 4'b0000);

        // Fixed priority with the same drop pattern.
        step(4'b1111, 1'b1, 1'b0);
        check("fp_0", 4'b0001);
        step(4'b1110, 1'b1, 1'b0);
        check("fp_1", 4'b0010);
        step(4'b1101, 1'b1, 1'b0);
        check("fp_2", 4'b0001);
        step(4'b1110, 1'b1, 1'b0);
        check("fp_3", 4'b0010);

        // Mode change while owner 2 holds the grant.
        step(4'b0000, 1'b0, 1'b0);
        check("mc_idle", 4'b0000);
        step(4'b0100, 1'b0, 1'b0);
        check("mc_owner2", 4'b0100);
        step(4'b0111, 1'b1, 1'b0);
        check("mc_keep_a", 4'b0100);
        step(4'b0111, 1'b1, 1'b0);
        check("mc_keep_b", 4'b0100);
        step(4'b0011, 1'b1, 1'b0);
        check("mc_handoff", 4'b0001);

        // Hold limit: two requesters held constant.
        step(4'b0000, 1'b1, 1'b0);
        check("hl_idle", 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step(4'b0011, 1'b1, 1'b0);
            if (HOLD_EN) exp = (i < MAX_HOLD) ? 4'b0001 : (i < 2 * MAX_HOLD) ? 4'b0010 : 4'b0001;
            else         exp = 4'b0001;
            check($sformatf("hold_%0d", i), exp);
        end

        // Randomized traffic: sticky requests, occasional mode flips and resets.
        rq = 4'b0000;
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            if ($urandom_range(0, 15) == 0) md = ~md;
            step(rq, md, ($urandom_range(0, 149) == 0));
        end
        step(4'b0000, 1'b0, 1'b1);
        check("final_reset", 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised N-way arbiter with registered one-hot and binary grant outputs.
- Two selectable policies: round-robin and fixed priority.
- Grant locks to the owner while its request stays high; optional hold-limit preemption.
- Sits in front of shared resources (bus, memory port) as the generalised successor of the fixed 4-way arbiter.

Parameters:
- N, 4, number of requesters; must be >= 2.
- MAX_HOLD, 8, maximum consecutive owner cycles before forced handoff; >= 1; used only when ARB_HOLD_LIMIT_EN is defined.
- IDW, $clog2(N), width of o_gnt_id; derived, not overridden.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  N  per-requester request, level-sensitive.
- i_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- o_gnt  output  N  one-hot grant, registered; zero when idle.
- o_gnt_id  output  IDW  binary index of the owner; 0 when idle.
- o_busy  output  1  1 while any grant is active (== |o_gnt).

Behaviour:
- Reset (i_rst=1 at an edge):
  - Next edge: o_gnt=0, o_gnt_id=0, o_busy=0, state=IDLE, last_owner=N-1 (first RR search starts at 0), hold_cnt=0.
  - Reset wins over any request, including mid-grant.
- State IDLE:
  - If |i_req at an edge: select a winner; o_gnt/o_gnt_id update on that edge; go to GRANT; hold_cnt=0.
  - Latency: request sampled at edge k -> grant visible after edge k.
  - Otherwise stay in IDLE.
- State GRANT (owner = o_gnt_id):
  - i_req[owner]=1, no preemption: keep grant; hold_cnt increments, saturating at MAX_HOLD-1.
  - i_req[owner]=0 and other bits set: new winner granted on the same edge. No idle bubble; o_gnt never passes through 0.
  - i_req[owner]=0 and i_req all 0: o_gnt=0, go to IDLE.
- Winner selection:
  - Round-robin (i_mode=0): scan indices last_owner+1, +2, ... modulo N; the first set request wins. Wrap from N-1 to 0 is required.
  - Fixed priority (i_mode=1): lowest set index wins.
  - On every new grant: last_owner <= winner, hold_cnt <= 0.
  - i_mode is sampled only at a selection decision; changing it mid-grant does not disturb the current owner.
  - Requests seen by the selector exclude the current owner on release or preemption.
- Invariants:
  - o_gnt is always zero or one-hot.
  - o_gnt_id always matches o_gnt.
  - A grant is never issued to an index whose i_req was 0 at the deciding edge.
- Simultaneous events: owner release plus a new request at the same edge resolves by the selection rule above, in one edge.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - In GRANT, if hold_cnt == MAX_HOLD-1 and any non-owner request is set, the next edge forces a handoff to the selected non-owner. This applies even if i_req[owner] is still 1.
  - If no other requester is present, the owner keeps the grant and hold_cnt stays saturated.
  - MAX_HOLD=1 gives single-cycle grants under contention.
- Undefined:
  - No preemption; the owner keeps the grant until its request drops.
  - hold_cnt logic is removed.

Test Plan:
- Reset: i_rst=1 for 3 cycles with i_req=4'b1111 -> o_gnt=0, o_gnt_id=0, o_busy=0 through reset. First grant after release is 4'b0001.
- Single request: i_req=4'b1000 from edge k -> o_gnt=4'b1000, o_gnt_id=3 after edge k, held while asserted. i_req=0 -> o_gnt=0 after the next edge.
- Round-robin rotation, wrap and back-to-back handoff:
  - Setup: i_mode=0, all requests high; each owner drops its request for exactly one cycle after being granted.
  - Required grant sequence: 0001, 0010, 0100, 1000, 0001.
  - o_gnt is never 0 between grants.
- Fixed priority: i_mode=1, same stimulus -> grants alternate 0001, 0010, 0001, 0010; indices 2 and 3 are never granted.
- Mode change mid-grant: owner 2 granted in RR mode; set i_mode=1 while i_req=4'b0111 held -> owner 2 retained. After req2 drops, the grant goes to 0001.
- Hold limit: i_req=4'b0011 held constant, MAX_HOLD=8.
  - With ARB_HOLD_LIMIT_EN: 0001 for 8 cycles, 0010 for 8 cycles, then 0001.
  - Without the macro: 0001 indefinitely.
